// File: rtl/sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_sequencer
// Brief    : Drives one SHA-256 compression through an external round datapath,
//            expanding the message schedule from a 16-word sliding window.
// Revision : 1.0
// ============================================================================
module sha256_round_sequencer #(
    parameter int ROUNDS   = 64,
    parameter int IDLE_GAP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_we,
    input  logic [3:0]  msg_addr,
    input  logic [31:0] msg_data,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        init_en,
    output logic        round_en,
    output logic [5:0]  round_idx,
    output logic [31:0] k_out,
    output logic [31:0] w_out,
    output logic        ff_en
);

    localparam logic [5:0] c_last_t   = 6'(ROUNDS - 1);
    localparam logic [3:0] c_gap_init = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_GAP   = 3'd3,
        S_FINAL = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;
    logic [3:0]  r_gap;
    logic        r_last;
    logic [31:0] w_expand;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_expand = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    // A gap follows every round strobe, the last one included, so a block
    // always spans 3 + ROUNDS*(1+IDLE_GAP) cycles from start to done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_gap     <= '0;
            r_last    <= 1'b0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            init_en   <= 1'b0;
            round_en  <= 1'b0;
            ff_en     <= 1'b0;
            round_idx <= '0;
            k_out     <= '0;
            w_out     <= '0;
        end else begin
            done     <= 1'b0;
            init_en  <= 1'b0;
            round_en <= 1'b0;
            ff_en    <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                round_idx <= '0;
                k_out     <= '0;
                w_out     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (msg_we) r_win[msg_addr] <= msg_data;
                        if (start && !abort) begin
                            r_state <= S_INIT;
                            init_en <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    S_INIT: begin
                        r_state   <= S_ROUND;
                        r_t       <= '0;
                        round_en  <= 1'b1;
                        round_idx <= '0;
                        k_out     <= c_k[0];
                        w_out     <= r_win[0];
                    end
                    S_ROUND: begin
                        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                        r_win[15] <= w_expand;
                        r_last    <= (r_t == c_last_t);
                        if (r_t != c_last_t) r_t <= r_t + 6'd1;
                        if (IDLE_GAP > 0) begin
                            r_state <= S_GAP;
                            r_gap   <= c_gap_init;
                        end else if (r_t == c_last_t) begin
                            r_state   <= S_FINAL;
                            ff_en     <= 1'b1;
                            round_idx <= '0;
                            k_out     <= '0;
                            w_out     <= '0;
                        end else begin
                            round_en  <= 1'b1;
                            round_idx <= r_t + 6'd1;
                            k_out     <= c_k[r_t + 6'd1];
                            w_out     <= r_win[1];
                        end
                    end
                    S_GAP: begin
                        if (r_gap != 4'd0) begin
                            r_gap <= r_gap - 4'd1;
                        end else if (r_last) begin
                            r_state   <= S_FINAL;
                            ff_en     <= 1'b1;
                            round_idx <= '0;
                            k_out     <= '0;
                            w_out     <= '0;
                        end else begin
                            r_state   <= S_ROUND;
                            round_en  <= 1'b1;
                            round_idx <= r_t;
                            k_out     <= c_k[r_t];
                            w_out     <= r_win[0];
                        end
                    end
                    S_FINAL: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sha256_round_sequencer
// Brief    : Directed bench with a reference round datapath and schedule model.
// Revision : 1.0
// ============================================================================
module tb_sha256_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_we = 1'b0;
    logic [3:0]  msg_addr = '0;
    logic [31:0] msg_data = '0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        abort = 1'b0;
    logic        abort2 = 1'b0;

    logic        busy, done, init_en, round_en, ff_en;
    logic [5:0]  round_idx;
    logic [31:0] k_out, w_out;
    logic        busy2, done2, init_en2, round_en2, ff_en2;
    logic [5:0]  round_idx2;
    logic [31:0] k_out2, w_out2;

    sha256_round_sequencer #(.ROUNDS(64), .IDLE_GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
        .start(start), .abort(abort), .busy(busy), .done(done), .init_en(init_en),
        .round_en(round_en), .round_idx(round_idx), .k_out(k_out), .w_out(w_out), .ff_en(ff_en)
    );

    sha256_round_sequencer #(.ROUNDS(64), .IDLE_GAP(2)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
        .start(start2), .abort(abort2), .busy(busy2), .done(done2), .init_en(init_en2),
        .round_en(round_en2), .round_idx(round_idx2), .k_out(k_out2), .w_out(w_out2), .ff_en(ff_en2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;

    logic [31:0] blk   [16];
    logic [31:0] w_exp [64];
    logic [31:0] hs    [8];
    logic [31:0] st    [8];

    int n_round, first_rnd, last_rnd, init_cyc, ff_cyc, done_cyc, n_ff, n_done;
    int busy_first, busy_last, idx_err, w_err;
    bit seen_busy;
    logic [31:0] w16, w17, k0, k63;
    int n_round2, first2, last2, prev2, done2_cyc, n_done2, space_err2, w_err2;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference datapath and event log for the IDLE_GAP=0 instance.
    always @(negedge clk) begin
        logic [31:0] t1, t2;
        int rel;
        rel = cyc - base;
        if (init_en) begin
            init_cyc = rel;
            for (int i = 0; i < 8; i++) st[i] = hs[i];
        end
        if (round_en) begin
            if (n_round == 0) first_rnd = rel;
            last_rnd = rel;
            if (round_idx !== 6'(n_round)) idx_err++;
            if (n_round < 64 && w_out !== w_exp[n_round]) w_err++;
            if (n_round == 16) w16 = w_out;
            if (n_round == 17) w17 = w_out;
            if (n_round == 0)  k0  = k_out;
            if (n_round == 63) k63 = k_out;
            n_round++;
            t1 = st[7] + (rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25))
                 + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k_out + w_out;
            t2 = (rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22))
                 + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
            st[7] = st[6]; st[6] = st[5]; st[5] = st[4]; st[4] = st[3] + t1;
            st[3] = st[2]; st[2] = st[1]; st[1] = st[0]; st[0] = t1 + t2;
        end
        if (ff_en) begin
            n_ff++;
            ff_cyc = rel;
            for (int i = 0; i < 8; i++) hs[i] = hs[i] + st[i];
        end
        if (done) begin
            n_done++;
            done_cyc = rel;
        end
        if (busy) begin
            if (!seen_busy) busy_first = rel;
            seen_busy = 1'b1;
            busy_last = rel;
        end
        if (round_en2) begin
            if (n_round2 == 0) first2 = rel;
            else if (rel - prev2 != 3) space_err2++;
            if (n_round2 < 64 && w_out2 !== w_exp[n_round2]) w_err2++;
            prev2 = rel;
            last2 = rel;
            n_round2++;
        end
        if (done2) begin
            n_done2++;
            done2_cyc = rel;
        end
    end

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        for (int t = 0; t < 64; t++)
            w_exp[t] = (t < 16) ? blk[t]
                     : ms1(w_exp[t-2]) + w_exp[t-7] + ms0(w_exp[t-15]) + w_exp[t-16];
    endtask

    task automatic load_block();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            msg_we = 1'b1; msg_addr = 4'(i); msg_data = blk[i];
        end
        @(negedge clk);
        msg_we = 1'b0;
    endtask

    task automatic clear_mon();
        n_round = 0; first_rnd = -1; last_rnd = -1; init_cyc = -1; ff_cyc = -1; done_cyc = -1;
        n_ff = 0; n_done = 0; busy_first = -1; busy_last = -1; idx_err = 0; w_err = 0;
        seen_busy = 1'b0; w16 = '0; w17 = '0; k0 = '0; k63 = '0;
        n_round2 = 0; first2 = -1; last2 = -1; prev2 = 0; done2_cyc = -1; n_done2 = 0;
        space_err2 = 0; w_err2 = 0;
    endtask

    task automatic start_dut();
        clear_mon();
        hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        @(negedge clk);
        start = 1'b1;
        base = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_round(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (round_en && round_idx == 6'(idx)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    localparam logic [255:0] c_abc_digest =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    initial begin
        bit ok;
        clear_mon();
        set_abc();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, init_en, round_en, ff_en, round_idx, k_out, w_out}, '0);
        rst_n = 1'b1;

        // "abc" block with cycle-accurate timing
        load_block();
        start_dut();
        repeat (75) @(negedge clk);
        chk("init_cycle", init_cyc, 1);
        chk("first_round_cycle", first_rnd, 2);
        chk("last_round_cycle", last_rnd, 65);
        chk("ff_cycle", ff_cyc, 66);
        chk("done_cycle", done_cyc, 67);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, 66);
        chk("round_count", n_round, 64);
        chk("round_idx_seq_errs", idx_err, 0);
        chk("w_seq_errs", w_err, 0);
        chk("w_t16", w16, 32'h61626380);
        chk("w_t17", w17, 32'h000F0000);
        chk("k_t0", k0, 32'h428a2f98);
        chk("k_t63", k63, 32'hc67178f2);
        chk("done_count", n_done, 1);
        chk("digest_abc", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, c_abc_digest);

        // abort together with start in IDLE: start is dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", {busy, init_en}, 2'b00);

        // abort during round 10
        load_block();
        start_dut();
        wait_round(10, ok);
        chk("reach_t10", ok, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_next_cycle", {busy, round_en, k_out, w_out}, '0);
        repeat (80) @(negedge clk);
        chk("abort_no_ff", n_ff, 0);
        chk("abort_no_done", n_done, 0);
        load_block();
        start_dut();
        repeat (75) @(negedge clk);
        chk("after_abort_rounds", n_round, 64);
        chk("digest_after_abort", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, c_abc_digest);

        // start and msg_we mid-run are ignored
        load_block();
        start_dut();
        wait_round(20, ok);
        chk("reach_t20", ok, 1'b1);
        start = 1'b1; msg_we = 1'b1; msg_addr = 4'd0; msg_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; msg_we = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrun_rounds", n_round, 64);
        chk("midrun_w_errs", w_err, 0);
        chk("midrun_done_count", n_done, 1);
        chk("digest_midrun", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, c_abc_digest);

        // asynchronous reset at round 30
        load_block();
        start_dut();
        wait_round(30, ok);
        chk("reach_t30", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, done, init_en, round_en, ff_en, round_idx, k_out, w_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        load_block();
        start_dut();
        repeat (75) @(negedge clk);
        chk("after_reset_rounds", n_round, 64);
        chk("digest_after_reset", {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]}, c_abc_digest);

        // IDLE_GAP=2 instance
        load_block();
        clear_mon();
        @(negedge clk);
        start2 = 1'b1;
        base = cyc;
        @(negedge clk);
        start2 = 1'b0;
        repeat (205) @(negedge clk);
        chk("gap_round_count", n_round2, 64);
        chk("gap_first_round", first2, 2);
        chk("gap_last_round", last2, 191);
        chk("gap_spacing_errs", space_err2, 0);
        chk("gap_w_errs", w_err2, 0);
        chk("gap_done_cycle", done2_cyc, 195);
        chk("gap_done_count", n_done2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
